// File: rtl/led_pattern_gen.sv
// led_pattern_gen
// ---------------
// Multi-channel LED pattern generator. Each of NUM_CH channels runs one of
// OFF, ON, BLINK or BREATHE (triangle-ramped PWM). All channels advance on a
// shared prescaler tick, and a debounced pushbutton freezes or resumes every
// pattern. Channels are configured through a single-cycle write port.
//
// Ports
//   clk       sole clock
//   rst_n     asynchronous active-low reset
//   button    raw active-low pushbutton, asynchronous to clk
//   cfg_we    single-cycle write strobe
//   cfg_ch    target channel; values >= NUM_CH are ignored
//   cfg_sel   0: write mode (cfg_data[1:0]), 1: write interval (cfg_data)
//   cfg_data  write data
//   led       LED drive, active-high, registered
//   tick      prescaler pulse, one cycle every PRESCALE cycles, registered
//   frozen    freeze state, registered
module led_pattern_gen #(
  parameter int CLK_HZ    = 24_000_000,
  parameter int TICK_HZ   = 1_000,
  parameter int NUM_CH    = 3,
  parameter int PER_W     = 16,
  parameter int PWM_W     = 8,
  parameter int DEB_TICKS = 20,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              button,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_sel,
  input  logic [PER_W-1:0]  cfg_data,
  output logic [NUM_CH-1:0] led,
  output logic              tick,
  output logic              frozen
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PCNT_W   = $clog2(PRESCALE);
  localparam int DEB_W    = $clog2(DEB_TICKS + 1);

  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);
  localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_TICKS - 1);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  localparam logic [PER_W-1:0]  PER_ONE   = PER_W'(1);
  localparam logic [PER_W-1:0]  RST_INTV  = PER_W'(TICK_HZ / 2);
  localparam logic [PWM_W-1:0]  LEV_ONE   = PWM_W'(1);
  localparam logic [PWM_W-1:0]  LEV_PEAK  = {PWM_W{1'b1}};

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e             mode;
    logic [PER_W-1:0]  intv;   // step interval, in ticks
    logic [PER_W-1:0]  ctr;    // ticks since the last step
    logic              phase;  // BLINK output level
    logic [PWM_W-1:0]  lev;    // BREATHE brightness
    logic              dir;    // BREATHE ramp direction, 1 = falling
  } ch_t;

  localparam ch_t CH_RST = '{
    mode:  MODE_BLINK,
    intv:  RST_INTV,
    ctr:   '0,
    phase: 1'b0,
    lev:   '0,
    dir:   1'b0
  };

  // Last ctr value before a step: max(intv,1) - 1. A zero interval behaves
  // like an interval of one.
  function automatic logic [PER_W-1:0] last_count(input logic [PER_W-1:0] intv);
    return (intv == '0) ? '0 : intv - PER_ONE;
  endfunction

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  logic [PCNT_W-1:0] pcnt_q;
  logic [PCNT_W-1:0] pcnt_d;

  always_comb begin
    pcnt_d = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + PCNT_ONE;
  end

  // tick is registered from the next count, so it is high exactly while
  // pcnt_q == PRESCALE-1.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      tick   <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      tick   <= (pcnt_d == PCNT_LAST);
    end
  end

  // ---------------------------------------------------------------------------
  // Button synchroniser, debounce and freeze toggle
  // ---------------------------------------------------------------------------
  logic [1:0]       sync_q;
  logic             btn_sync;
  logic             deb_level_q;
  logic             deb_level_d;
  logic [DEB_W-1:0] deb_cnt_q;
  logic [DEB_W-1:0] deb_cnt_d;
  logic             press;

  assign btn_sync = sync_q[1];

  // The counter clears on any cycle where the synchronised input agrees with
  // the accepted level, so only an unbroken disagreement spanning DEB_TICKS
  // ticks is accepted.
  // NOTE: every combinational output gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    deb_cnt_d   = deb_cnt_q;
    deb_level_d = deb_level_q;
    press       = 1'b0;
    if (btn_sync == deb_level_q) begin
      deb_cnt_d = '0;
    end else if (tick) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_cnt_d   = '0;
        deb_level_d = btn_sync;
        press       = ~btn_sync;  // accepted 1->0 edge only
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;  // released
      deb_level_q <= 1'b1;
      deb_cnt_q   <= '0;
      frozen      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], button};
      deb_level_q <= deb_level_d;
      deb_cnt_q   <= deb_cnt_d;
      frozen      <= frozen ^ press;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared PWM counter (never freezes, so a frozen BREATHE level holds steady)
  // ---------------------------------------------------------------------------
  logic [PWM_W-1:0] pwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + LEV_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Channel state
  // ---------------------------------------------------------------------------
  ch_t ch_q [NUM_CH];
  ch_t ch_d [NUM_CH];

  // The tick advance is computed first and a write then overrides it: a mode
  // write discards the same-cycle advance, an interval write replaces only
  // intv so the advance was judged against the old interval.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_d[i] = ch_q[i];

      if (tick && !frozen) begin
        // >= rather than == so an interval shrunk below ctr wraps next tick.
        if (ch_q[i].ctr >= last_count(ch_q[i].intv)) begin
          ch_d[i].ctr = '0;
          case (ch_q[i].mode)
            MODE_BLINK: begin
              ch_d[i].phase = ~ch_q[i].phase;
            end
            MODE_BREATHE: begin
              if (!ch_q[i].dir) begin
                ch_d[i].lev = ch_q[i].lev + LEV_ONE;
                if (ch_q[i].lev == LEV_PEAK - LEV_ONE) ch_d[i].dir = 1'b1;
              end else begin
                ch_d[i].lev = ch_q[i].lev - LEV_ONE;
                if (ch_q[i].lev == LEV_ONE) ch_d[i].dir = 1'b0;
              end
            end
            default: ;
          endcase
        end else begin
          ch_d[i].ctr = ch_q[i].ctr + PER_ONE;
        end
      end

      // Out-of-range channel numbers never match any i and are dropped.
      if (cfg_we && (int'(cfg_ch) == i)) begin
        if (!cfg_sel) begin
          ch_d[i].mode  = mode_e'(cfg_data[1:0]);
          ch_d[i].ctr   = '0;
          ch_d[i].phase = 1'b0;
          ch_d[i].lev   = '0;
          ch_d[i].dir   = 1'b0;
        end else begin
          ch_d[i].intv  = cfg_data;
        end
      end
    end
  end

  // NOTE: the channel array is a handful of flops, not a RAM, so resetting
  // every entry is legal and required for a defined power-up pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= CH_RST;
    end else begin
      for (int i = 0; i < NUM_CH; i++) ch_q[i] <= ch_d[i];
    end
  end

  // ---------------------------------------------------------------------------
  // LED output
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] led_d;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      led_d[i] = 1'b0;
      case (ch_q[i].mode)
        MODE_OFF:     led_d[i] = 1'b0;
        MODE_ON:      led_d[i] = 1'b1;
        MODE_BLINK:   led_d[i] = ch_q[i].phase;
        MODE_BREATHE: led_d[i] = (pwm_q < ch_q[i].lev);
        default:      led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      led <= led_d;
    end
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Multi-channel LED pattern generator for board bring-up and status indication. It replaces the single free-running LED counter with NUM_CH independently configurable channels, each running OFF, ON, BLINK or BREATHE (triangle-ramped PWM). All channels share one clock prescaler, and a debounced pushbutton freezes or resumes every pattern. It sits directly in front of the board LED pins and is configured by the design's control logic through a simple write port.

## Interface
- CLK_HZ, 24_000_000, input clock frequency.
- TICK_HZ, 1_000, pattern tick rate. PRESCALE = CLK_HZ/TICK_HZ; must be ≥ 2.
- NUM_CH, 3, number of LED channels (≥ 1).
- PER_W, 16, width of each channel's interval register, in ticks.
- PWM_W, 8, BREATHE brightness resolution.
- DEB_TICKS, 20, number of consecutive ticks the button must be stable to be accepted.
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- button  in  1  raw active-low pushbutton; asynchronous to clk.
- cfg_we  in  1  single-cycle write strobe.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel.
- cfg_sel  in  1  0 selects mode (cfg_data[1:0]); 1 selects interval (cfg_data).
- cfg_data  in  PER_W  write data.
- led  out  NUM_CH  LED drive, active-high, registered.
- tick  out  1  prescaler pulse, registered.
- frozen  out  1  freeze state, registered.

## Operation
- **Prescaler:** pcnt counts 0..PRESCALE-1 and wraps. tick is high for exactly one cycle while pcnt == PRESCALE-1, giving a period of exactly PRESCALE cycles with no off-by-one.
- **Per-channel state:** mode (2b), intv (PER_W), ctr (PER_W), phase (1b), lev (PWM_W), dir (1b).
- **Reset values:** mode = BLINK (2), intv = TICK_HZ/2 truncated to PER_W, ctr = phase = lev = dir = 0, pcnt = 0, frozen = 0. All outputs are 0.
- **Channel advance:** on a tick while not frozen:
  - if ctr ≥ max(intv,1) - 1, then ctr ← 0 and a step event occurs;
  - otherwise ctr ← ctr + 1.
  - The ≥ compare makes an interval reduced mid-run take effect on the next tick.
- **Step event, BLINK:** phase toggles.
- **Step event, BREATHE:** lev ← lev + 1 when dir = 0, lev ← lev - 1 when dir = 1.
  - dir becomes 1 when lev reaches 2^PWM_W - 1.
  - dir becomes 0 when lev reaches 0.
  - The result is a triangle ramp with no hold at the peaks.
- **LED value by mode:**
  - OFF (0): 0.
  - ON (1): 1.
  - BLINK (2): phase.
  - BREATHE (3): (pwm < lev). pwm is a shared PWM_W-bit free-running counter that increments every clk and never freezes.
- **Mode write (cfg_sel = 0):** updates mode and clears ctr, phase, lev and dir of that channel, restarting the pattern.
- **Interval write (cfg_sel = 1):** updates intv only. ctr continues counting.
- **Invalid channel:** a write with cfg_ch ≥ NUM_CH is ignored.
- **Write and tick on the same cycle, same channel:**
  - Mode write: the write wins and the tick is dropped for that channel.
  - Interval write: the tick is evaluated against the old intv.
- **Button path:**
  - Two-flop synchroniser.
  - Debounce counter runs on ticks. The debounced level changes only after the synchronised input has differed from it for DEB_TICKS consecutive ticks. Any reversion clears the counter.
  - Debounced reset value is 1 (released).
  - Each debounced 1→0 transition (press) toggles frozen. Release has no effect.
- **Frozen behaviour:**
  - ctr, phase, lev and dir hold.
  - cfg writes are still accepted, and a mode write still clears state.
  - pwm keeps running, so BREATHE brightness holds steady.
- **Reset mid-operation:** all state returns to reset values immediately and asynchronously.

## Timing
- tick: high in the cycle where pcnt == PRESCALE-1. The first tick is in cycle PRESCALE-1 after reset release.
- Channel state updates on the clk edge that samples tick high.
- led is registered from channel state, so one further cycle of latency.
- Config write: cfg_we sampled at edge N updates state at N. led reflects the new value at edge N+1.
- Button to frozen: 2 synchroniser cycles + DEB_TICKS ticks + 1 cycle.
- BLINK period = 2·max(intv,1)·PRESCALE cycles.
- BREATHE full cycle = 2·(2^PWM_W - 1)·max(intv,1)·PRESCALE cycles.

## Test plan
Parameters for all scenarios unless stated: CLK_HZ = 100, TICK_HZ = 10, NUM_CH = 3, PER_W = 8, PWM_W = 3, DEB_TICKS = 2.
- **Reset default:** release rst_n.
  - tick pulses at cycles 9, 19, 29, ….
  - All led bits are 0 until the 5th tick, then 1 one cycle later.
  - led toggles every 50 cycles.
- **Mode write:** write ch1 mode = ON.
  - led[1] = 1 two edges after the strobe.
  - Writing mode = OFF returns it to 0.
  - A write with cfg_ch = 3 changes nothing.
- **Interval shrink:** ch0 in BLINK with intv = 5. At ctr = 4, write intv = 2.
  - ctr wraps on the next tick and phase toggles.
  - Following toggles are every 20 cycles.
- **BREATHE ramp:** ch2 set to BREATHE with intv = 1.
  - lev steps 0, 1, …, 7, 6, …, 0 every tick.
  - Within each aligned 8-cycle pwm window, led[2] is high for exactly lev cycles.
- **Button debounce and freeze:**
  - A 1-tick low glitch leaves frozen = 0.
  - Low for 3 ticks sets frozen = 1. led and lev then hold; tick continues.
  - A second press clears frozen = 0 and the pattern resumes from the held state.
- **Async reset mid-pattern:** assert rst_n during BREATHE.
  - led, tick and frozen are 0 immediately, with no clock edge required.
  - After release, the reset-default behaviour repeats exactly.
